// File: rtl/rambus_stream_pkg.sv
// Shared types and constants for the rambus stream reader.
package rambus_stream_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
  localparam int unsigned WB_ADR_WIDTH       = 10;
  localparam int unsigned WB_DATA_WIDTH      = 32;
  localparam int unsigned WDOG_WIDTH         = 8;
  localparam int unsigned TIMEOUT_LIMIT      = 255;
  localparam logic [3:0]  SEL_ALL            = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with single-cycle flush, full/empty flags and occupancy count.
module stream_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  // Qualified push/pop and the occupancy they produce
  always_comb begin
    do_push = push && !full_q;
    do_pop  = pop && !empty_q;
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers and flags; flush overrides any push/pop in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Data storage; contents are don't-care while empty so no reset
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

endmodule

// File: rtl/rambus_stream_reader.sv
// Wishbone read master that streams a run of consecutive RAM words through a FIFO.
// Optional bus watchdog: define RAMBUS_STREAM_TIMEOUT_EN.
module rambus_stream_reader
  import rambus_stream_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [ADDR_WIDTH-1:0]    base_addr_i,
  input  logic [ADDR_WIDTH:0]      length_i,
  input  logic                     loop_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic                     rambus_wb_clk_o,
  output logic                     rambus_wb_rst_o,
  output logic                     rambus_wb_cyc_o,
  output logic                     rambus_wb_stb_o,
  output logic                     rambus_wb_we_o,
  output logic [3:0]               rambus_wb_sel_o,
  output logic [WB_DATA_WIDTH-1:0] rambus_wb_dat_o,
  output logic [WB_ADR_WIDTH-1:0]  rambus_wb_adr_o,
  input  logic                     rambus_wb_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] rambus_wb_dat_i,
  output logic [WB_DATA_WIDTH-1:0] m_data_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  loop_q, loop_d;
  logic                  cyc_q, cyc_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_flush;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

`ifdef RAMBUS_STREAM_TIMEOUT_EN
  logic [WDOG_WIDTH-1:0] wdog_q, wdog_d;
  logic                  error_q, error_d;
`endif

  // Output FIFO between bus reads and the stream port
  stream_fifo #(
    .WIDTH (WB_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (rambus_wb_dat_i),
    .pop       (fifo_pop),
    .pop_data  (m_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign fifo_pop  = !fifo_empty && m_ready_i;
  assign m_valid_o = !fifo_empty;

  // State and registered bus/status outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
`ifdef RAMBUS_STREAM_TIMEOUT_EN
      wdog_q  <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      base_q  <= base_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
`ifdef RAMBUS_STREAM_TIMEOUT_EN
      wdog_q  <= wdog_d;
      error_q <= error_d;
`endif
    end
  end

  // Next-state: one outstanding read, one idle bus cycle after each ack
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    base_d     = base_q;
    len_d      = len_q;
    loop_d     = loop_q;
    cyc_d      = cyc_q;
    busy_d     = busy_q;
    abort_d    = abort_q;
    done_d     = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
`ifdef RAMBUS_STREAM_TIMEOUT_EN
    error_d = error_q;
    wdog_d  = (state_q == ST_REQ && cyc_q && !rambus_wb_ack_i) ?
              wdog_q + WDOG_WIDTH'(1) : '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
`ifdef RAMBUS_STREAM_TIMEOUT_EN
          error_d = 1'b0;
`endif
          base_d = base_addr_i;
          len_d  = length_i;
          loop_d = loop_i;
          if (length_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_REQ;
            addr_d  = base_addr_i;
            rem_d   = length_i;
            cyc_d   = !fifo_full;
            busy_d  = 1'b1;
          end
        end
      end

      ST_REQ: begin
        if (cyc_q) begin
          if (rambus_wb_ack_i) begin
            cyc_d = 1'b0;
            if (stop_i || abort_q) begin
              fifo_flush = 1'b1;
              abort_d    = 1'b0;
              busy_d     = 1'b0;
              state_d    = ST_IDLE;
            end else begin
              fifo_push = 1'b1;
              addr_d    = addr_q + ADDR_WIDTH'(1);
              rem_d     = rem_q - LEN_W'(1);
              state_d   = ST_GAP;
            end
          end
`ifdef RAMBUS_STREAM_TIMEOUT_EN
          else if (wdog_q == WDOG_WIDTH'(TIMEOUT_LIMIT - 1)) begin
            cyc_d      = 1'b0;
            error_d    = 1'b1;
            fifo_flush = 1'b1;
            abort_d    = 1'b0;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
          end
`endif
          else if (stop_i) begin
            abort_d    = 1'b1;
            fifo_flush = 1'b1;
          end
        end else if (stop_i) begin
          fifo_flush = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else if (!fifo_full) begin
          cyc_d = 1'b1;
        end
      end

      ST_GAP: begin
        if (stop_i) begin
          fifo_flush = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else if (rem_q != '0) begin
          state_d = ST_REQ;
          cyc_d   = !fifo_full;
        end else if (loop_q) begin
          addr_d  = base_q;
          rem_d   = len_q;
          state_d = ST_REQ;
          cyc_d   = !fifo_full;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (stop_i) begin
          fifo_flush = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else if (fifo_count == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
`ifdef RAMBUS_STREAM_TIMEOUT_EN
  assign error_o         = error_q;
`else
  assign error_o         = 1'b0;
`endif
  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = ~wb_rst_ni;
  assign rambus_wb_cyc_o = cyc_q;
  assign rambus_wb_stb_o = cyc_q;
  assign rambus_wb_we_o  = 1'b0;
  assign rambus_wb_sel_o = SEL_ALL;
  assign rambus_wb_dat_o = '0;
  assign rambus_wb_adr_o = WB_ADR_WIDTH'({addr_q, 2'b00});

endmodule
